// File: rtl/level_pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | level_pwm_pkg                                                        |
// | Shared defaults and bus-slicing helper for the level PWM generator.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package level_pwm_pkg;

  localparam int c_default_width    = 8;
  localparam int c_default_channels = 2;
  localparam int c_max_width        = 32;
  localparam int c_max_bus          = 1024;

  // Returns channel idx of a flattened bus; callers narrow the result to their width.
  function automatic logic [c_max_width-1:0] channel_slice(
    input logic [c_max_bus-1:0] bus,
    input int                   idx,
    input int                   width
  );
    logic [c_max_width-1:0] mask;
    mask = (width >= c_max_width) ? '1 : ((c_max_width'(1) << width) - 1'b1);
    return c_max_width'(bus >> (idx * width)) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/level_ramp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | level_ramp                                                           |
// | Per-channel target capture and boundary-synchronous duty slew.       |
// | Optional macro: LEVEL_RAMP_EN (bounded slew instead of direct load). |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module level_ramp
  import level_pwm_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int STEP  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_level,
  input  logic             i_level_valid,
  input  logic             i_boundary,
  output logic [WIDTH-1:0] o_duty,
  output logic             o_at_target
);

  if (STEP < 1) begin : g_step_check
    $error("level_ramp: STEP must be at least 1");
  end

  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] w_eff_target;
  logic [WIDTH-1:0] w_next_duty;

  assign w_eff_target = i_enable ? r_target : '0;

`ifdef LEVEL_RAMP_EN
  // Step clamped to the full range so the WIDTH+1 bit compare stays exact.
  localparam logic [WIDTH:0] c_step = (STEP >= (2 ** WIDTH)) ? (WIDTH+1)'(2 ** WIDTH)
                                                             : (WIDTH+1)'(STEP);
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_diff      = '0;
    w_next_duty = r_duty;
    if (w_eff_target > r_duty) begin
      w_diff      = {1'b0, w_eff_target} - {1'b0, r_duty};
      w_next_duty = (w_diff > c_step) ? (r_duty + c_step[WIDTH-1:0]) : w_eff_target;
    end else begin
      w_diff      = {1'b0, r_duty} - {1'b0, w_eff_target};
      w_next_duty = (w_diff > c_step) ? (r_duty - c_step[WIDTH-1:0]) : w_eff_target;
    end
  end
`else
  assign w_next_duty = w_eff_target;
`endif

  // Duty is only touched on the wrap edge, so a period never sees two duties.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_target <= '0;
      r_duty   <= '0;
    end else begin
      if (i_boundary) begin
        r_duty <= w_next_duty;
      end
      if (i_level_valid) begin
        r_target <= i_level;
      end
    end
  end

  assign o_duty      = r_duty;
  assign o_at_target = (r_duty == w_eff_target);

endmodule
`default_nettype wire

// File: rtl/level_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | level_pwm_gen                                                        |
// | Multi-channel PWM with shared prescaled counter and per-channel duty.|
// | Optional macro: LEVEL_RAMP_EN (duty slews by at most STEP/period).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module level_pwm_gen
  import level_pwm_pkg::*;
#(
  parameter int WIDTH    = c_default_width,
  parameter int CHANNELS = c_default_channels,
  parameter int PRESCALE = 1,
  parameter int STEP     = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] level,
  input  logic                      level_valid,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       at_target,
  output logic                      busy
);

  logic                 w_tick;
  logic                 w_wrap;
  logic [WIDTH-1:0]     r_count;
  logic                 r_period_start;
  logic [CHANNELS-1:0]  r_pwm;
  logic [WIDTH-1:0]     w_duty [CHANNELS];
  logic [c_max_bus-1:0] w_level_ext;

  if (PRESCALE <= 1) begin : g_no_prescale
    assign w_tick = 1'b1;
  end else begin : g_prescale
    localparam int                 c_pre_w    = $clog2(PRESCALE);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);
    logic [c_pre_w-1:0] r_prescale;

    always_ff @(posedge clock) begin
      if (reset || (r_prescale == c_pre_last)) begin
        r_prescale <= '0;
      end else begin
        r_prescale <= r_prescale + 1'b1;
      end
    end

    assign w_tick = (r_prescale == c_pre_last);
  end

  assign w_wrap = w_tick && (r_count == '1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count        <= '0;
      r_period_start <= 1'b0;
    end else begin
      if (w_tick) begin
        r_count <= r_count + 1'b1;
      end
      r_period_start <= w_wrap;
    end
  end

  assign w_level_ext = c_max_bus'(level);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    logic [WIDTH-1:0] w_level_ch;
    assign w_level_ch = WIDTH'(channel_slice(w_level_ext, i, WIDTH));

    level_ramp #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_ramp (
      .clock         (clock),
      .reset         (reset),
      .i_enable      (enable),
      .i_level       (w_level_ch),
      .i_level_valid (level_valid),
      .i_boundary    (w_wrap),
      .o_duty        (w_duty[i]),
      .o_at_target   (at_target[i])
    );
  end

  // Compare against the pre-edge count: pwm lags the counter by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pwm[i] <= (r_count < w_duty[i]);
      end
    end
  end

  assign pwm          = r_pwm;
  assign period_start = r_period_start;
  assign busy         = |(~at_target);

endmodule
`default_nettype wire

// File: tb/tb_level_pwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_level_pwm_gen                                                     |
// | Self-checking bench: cycle-count reference model plus directed pins. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_level_pwm_gen;

  localparam int W0 = 8, CH0 = 2, PS0 = 1, ST0 = 16;
  localparam int W1 = 4, CH1 = 3, PS1 = 3, ST1 = 5;
`ifdef LEVEL_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [W0*CH0-1:0] level0 = '0;
  logic              valid0 = 1'b0;
  logic [W1*CH1-1:0] level1 = '0;
  logic              valid1 = 1'b0;

  logic [CH0-1:0] pwm0, at0;
  logic           ps0, busy0;
  logic [CH1-1:0] pwm1, at1;
  logic           ps1, busy1;

  int errors = 0;
  int checks = 0;

  // Model state: edges since reset, targets, duties, expected registered outputs.
  int m_cyc [2];
  int m_tgt [2][4];
  int m_duty[2][4];
  int m_pwm [2][4];
  int m_ps  [2];
  bit started = 1'b0;

  always #5 clock = ~clock;

  level_pwm_gen #(.WIDTH(W0), .CHANNELS(CH0), .PRESCALE(PS0), .STEP(ST0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .level(level0), .level_valid(valid0),
    .pwm(pwm0), .period_start(ps0), .at_target(at0), .busy(busy0)
  );

  level_pwm_gen #(.WIDTH(W1), .CHANNELS(CH1), .PRESCALE(PS1), .STEP(ST1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .level(level1), .level_valid(valid1),
    .pwm(pwm1), .period_start(ps1), .at_target(at1), .busy(busy1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ramp_to(input int d, input int t, input int st, input bit en);
    int delta;
    if (!en) return t;
    delta = t - d;
    if (delta > st) delta = st;
    if (delta < -st) delta = -st;
    return d + delta;
  endfunction

  // Counter value is simply (edges since reset / prescale) mod 2^w.
  task automatic model_step(input int k, input int w, input int ch, input int pre,
                            input int st, input logic [31:0] lvl, input logic vld);
    int  m, cnt;
    bit  wrap;
    if (reset) begin
      m_cyc[k] = 0;
      m_ps[k]  = 0;
      for (int i = 0; i < 4; i++) begin
        m_tgt[k][i] = 0; m_duty[k][i] = 0; m_pwm[k][i] = 0;
      end
      return;
    end
    m    = 1 << w;
    cnt  = (m_cyc[k] / pre) % m;
    wrap = ((m_cyc[k] % pre) == pre - 1) && (cnt == m - 1);
    for (int i = 0; i < ch; i++) begin
      m_pwm[k][i] = (cnt < m_duty[k][i]) ? 1 : 0;
      if (wrap) m_duty[k][i] = ramp_to(m_duty[k][i], enable ? m_tgt[k][i] : 0, st, RAMP_EN);
      if (vld)  m_tgt[k][i] = int'((lvl >> (i * w)) & 32'(m - 1));
    end
    m_ps[k]  = wrap ? 1 : 0;
    m_cyc[k] = m_cyc[k] + 1;
  endtask

  initial forever begin
    @(posedge clock);
    model_step(0, W0, CH0, PS0, ST0, 32'(level0), valid0);
    model_step(1, W1, CH1, PS1, ST1, 32'(level1), valid1);
    started = 1'b1;
  end

  initial forever begin
    int ea, full;
    @(posedge clock);
    #1;
    if (started) begin
      ea = 0; full = (1 << CH0) - 1;
      for (int i = 0; i < CH0; i++) begin
        check($sformatf("pwm0[%0d]", i), int'(pwm0[i]), m_pwm[0][i]);
        if (m_duty[0][i] == (enable ? m_tgt[0][i] : 0)) ea |= (1 << i);
      end
      check("period_start0", int'(ps0), m_ps[0]);
      check("at_target0", int'(at0), ea);
      check("busy0", int'(busy0), (ea != full) ? 1 : 0);
      ea = 0; full = (1 << CH1) - 1;
      for (int i = 0; i < CH1; i++) begin
        check($sformatf("pwm1[%0d]", i), int'(pwm1[i]), m_pwm[1][i]);
        if (m_duty[1][i] == (enable ? m_tgt[1][i] : 0)) ea |= (1 << i);
      end
      check("period_start1", int'(ps1), m_ps[1]);
      check("at_target1", int'(at1), ea);
      check("busy1", int'(busy1), (ea != full) ? 1 : 0);
    end
  end

  initial forever begin
    @(negedge clock);
    if ($urandom_range(7) == 0) begin
      level1 = 12'($urandom);
      valid1 = 1'b1;
    end else begin
      valid1 = 1'b0;
    end
  end

  task automatic wait_ps0();
    bit seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(posedge clock);
      #1;
      seen = ps0;
    end
    if (!seen) check("period_start0_timeout", 0, 1);
  endtask

  // Samples the 256 cycles following a period_start cycle.
  task automatic count_period(input bit drop_valid, output int h0, output int h1,
                              output int nps, output int lps);
    h0 = 0; h1 = 0; nps = 0;
    for (int n = 0; n < 256; n++) begin
      @(posedge clock);
      #1;
      if (drop_valid) valid0 = 1'b0;
      h0  += int'(pwm0[0]);
      h1  += int'(pwm0[1]);
      nps += int'(ps0);
    end
    lps = int'(ps0);
  endtask

  initial begin
    int h0, h1, nps, lps, n;
    bit seen, reached;

    repeat (3) @(negedge clock);
    check("reset_pwm", int'(pwm0), 0);
    check("reset_period_start", int'(ps0), 0);
    check("reset_at_target", int'(at0), 3);
    check("reset_busy", int'(busy0), 0);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clock); level0 = {8'd0, 8'd64}; valid0 = 1'b1;
    @(negedge clock); valid0 = 1'b0;

    wait_ps0();
    for (int p = 0; p < 4; p++) begin
      check("ramp_up_at_target", int'(at0[0]), RAMP_EN ? ((p == 3) ? 1 : 0) : 1);
      count_period(1'b0, h0, h1, nps, lps);
      check("ramp_up_duty", h0, RAMP_EN ? 16 * (p + 1) : 64);
      check("ramp_up_ch1", h1, 0);
      check("period_spacing", nps, 1);
      check("period_end", lps, 1);
    end
    check("model_duty_64", m_duty[0][0], 64);

    @(negedge clock); enable = 1'b0;
    for (int q = 0; q < 5; q++) begin
      count_period(1'b0, h0, h1, nps, lps);
      check("ramp_down_duty", h0, RAMP_EN ? 64 - 16 * q : ((q == 0) ? 64 : 0));
      check("ramp_down_busy", int'(busy0), RAMP_EN ? ((q < 3) ? 1 : 0) : 0);
    end

    @(negedge clock); level0 = '0; valid0 = 1'b1;
    @(negedge clock); valid0 = 1'b0; enable = 1'b1;
    wait_ps0();
    check("coincident_at_target", int'(at0[0]), 1);
    level0 = {8'd0, 8'd100};
    valid0 = 1'b1;
    count_period(1'b1, h0, h1, nps, lps);
    check("coincident_hold", h0, 0);
    count_period(1'b0, h0, h1, nps, lps);
    check("coincident_next", h0, RAMP_EN ? 16 : 100);
    count_period(1'b0, h0, h1, nps, lps);
    check("coincident_second", h0, RAMP_EN ? 32 : 100);

    @(negedge clock); level0 = {8'd0, 8'd255}; valid0 = 1'b1;
    @(negedge clock); valid0 = 1'b0;
    reached = 1'b0;
    for (int b = 0; b < 20 && !reached; b++) begin
      wait_ps0();
      reached = at0[0];
    end
    check("full_reached", int'(reached), 1);
    count_period(1'b0, h0, h1, nps, lps);
    check("full_high", h0, 255);
    check("zero_high", h1, 0);
    check("model_duty_255", m_duty[0][0], 255);

    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    @(negedge clock); level0 = {8'd0, 8'd64}; valid0 = 1'b1;
    @(negedge clock); valid0 = 1'b0;
    wait_ps0();
    wait_ps0();
    check("model_duty_32", m_duty[0][0], RAMP_EN ? 32 : 64);
    repeat (10) @(negedge clock);
    check("mid_ramp_pwm_high", int'(pwm0[0]), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("reset_mid_pwm", int'(pwm0), 0);
    check("reset_mid_at_target", int'(at0), 3);
    check("reset_mid_busy", int'(busy0), 0);
    @(negedge clock); reset = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 600 && !seen) begin
      @(posedge clock); #1;
      n++;
      seen = ps0;
    end
    check("restart_spacing", n, 256);

    for (int c = 0; c < 8000; c++) begin
      @(negedge clock);
      n = int'($urandom_range(999));
      reset = (n == 0);
      if (n < 5) enable = ~enable;
      if ($urandom_range(19) == 0) begin
        valid0 = 1'b1;
        case ($urandom_range(3))
          0:       level0 = '0;
          1:       level0 = '1;
          default: level0 = 16'($urandom);
        endcase
      end else begin
        valid0 = 1'b0;
      end
    end
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
